// File: rtl/junction_nway_ctrl.sv
// Demand-actuated N-way junction controller: one approach at a time through green, amber, all-red.
// Optional night-mode amber flash is enabled by defining JUNCTION_NIGHT_FLASH_EN.
module junction_nway_ctrl #(
    parameter int N_WAYS        = 3,
    parameter int GREEN_CYC     = 4,
    parameter int MAX_GREEN_CYC = 8,
    parameter int AMBER_CYC     = 2,
    parameter int ALLRED_CYC    = 1,
    parameter int FLASH_CYC     = 2,
    parameter int CNT_W         = 8,
    localparam int PW           = $clog2(N_WAYS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_WAYS-1:0] veh_req,
`ifdef JUNCTION_NIGHT_FLASH_EN
    input  logic              night_mode,
`endif
    output logic [N_WAYS-1:0] red,
    output logic [N_WAYS-1:0] amber,
    output logic [N_WAYS-1:0] green,
    output logic [PW-1:0]     phase
);

    typedef enum logic [1:0] {
        S_ALL_RED = 2'd0,
        S_GREEN   = 2'd1,
        S_AMBER   = 2'd2
`ifdef JUNCTION_NIGHT_FLASH_EN
        , S_FLASH = 2'd3
`endif
    } state_t;

    if (N_WAYS < 2 || N_WAYS > 16 || GREEN_CYC < 1 || MAX_GREEN_CYC < GREEN_CYC ||
        AMBER_CYC < 1 || ALLRED_CYC < 1 || FLASH_CYC < 1 ||
        MAX_GREEN_CYC >= (1 << CNT_W)) begin : g_bad_cfg
        $error("junction_nway_ctrl: illegal parameter combination");
    end

    state_t              r_state;
    logic [CNT_W-1:0]    r_timer;
    logic [CNT_W-1:0]    r_elapsed;
    logic [PW-1:0]       r_phase;
    logic [N_WAYS-1:0]   r_red, r_amber, r_green;
`ifdef JUNCTION_NIGHT_FLASH_EN
    logic [CNT_W-1:0]    r_flash_cnt;
    logic                r_flash_on;
`endif

    logic [PW-1:0]       w_next_phase;
    logic                w_found;
    logic [N_WAYS-1:0]   w_phase_oh, w_next_oh;
    logic                w_extend;
    logic [CNT_W-1:0]    w_elapsed_inc;

    // Circular search from phase+1; with no demand anywhere fall back to phase+1.
    always_comb begin
        w_next_phase = (r_phase == PW'(N_WAYS - 1)) ? '0 : r_phase + PW'(1);
        w_found      = 1'b0;
        for (int i = 1; i <= N_WAYS; i++) begin
            int idx;
            idx = int'(r_phase) + i;
            if (idx >= N_WAYS) idx = idx - N_WAYS;
            if (!w_found && veh_req[idx[PW-1:0]]) begin
                w_found      = 1'b1;
                w_next_phase = PW'(idx);
            end
        end
    end

    assign w_phase_oh    = {{(N_WAYS-1){1'b0}}, 1'b1} << r_phase;
    assign w_next_oh     = {{(N_WAYS-1){1'b0}}, 1'b1} << w_next_phase;
    assign w_extend      = veh_req[r_phase] && ((veh_req & ~w_phase_oh) == '0) &&
                           (r_elapsed < CNT_W'(MAX_GREEN_CYC));
    assign w_elapsed_inc = (r_elapsed < CNT_W'(MAX_GREEN_CYC)) ? r_elapsed + CNT_W'(1) : r_elapsed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_ALL_RED;
            r_timer     <= CNT_W'(ALLRED_CYC);
            r_elapsed   <= '0;
            r_phase     <= PW'(N_WAYS - 1);
            r_red       <= '1;
            r_amber     <= '0;
            r_green     <= '0;
`ifdef JUNCTION_NIGHT_FLASH_EN
            r_flash_cnt <= '0;
            r_flash_on  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_ALL_RED: begin
                    if (r_timer == CNT_W'(1)) begin
`ifdef JUNCTION_NIGHT_FLASH_EN
                        if (night_mode) begin
                            r_state     <= S_FLASH;
                            r_flash_cnt <= CNT_W'(FLASH_CYC);
                            r_flash_on  <= 1'b1;
                            r_red       <= '0;
                            r_amber     <= '1;
                            r_green     <= '0;
                        end else begin
`else
                        begin
`endif
                            r_state   <= S_GREEN;
                            r_phase   <= w_next_phase;
                            r_timer   <= CNT_W'(GREEN_CYC);
                            r_elapsed <= CNT_W'(1);
                            r_red     <= ~w_next_oh;
                            r_green   <= w_next_oh;
                            r_amber   <= '0;
                        end
                    end else begin
                        r_timer <= r_timer - CNT_W'(1);
                    end
                end
                S_GREEN: begin
                    // Minimum green runs on the timer; afterwards elapsed bounds the extension.
                    if (r_timer > CNT_W'(1)) begin
                        r_timer   <= r_timer - CNT_W'(1);
                        r_elapsed <= w_elapsed_inc;
                    end else if (w_extend) begin
                        r_elapsed <= w_elapsed_inc;
                    end else begin
                        r_state   <= S_AMBER;
                        r_timer   <= CNT_W'(AMBER_CYC);
                        r_elapsed <= '0;
                        r_amber   <= w_phase_oh;
                        r_green   <= '0;
                    end
                end
                S_AMBER: begin
                    if (r_timer == CNT_W'(1)) begin
                        r_state <= S_ALL_RED;
                        r_timer <= CNT_W'(ALLRED_CYC);
                        r_red   <= '1;
                        r_amber <= '0;
                    end else begin
                        r_timer <= r_timer - CNT_W'(1);
                    end
                end
`ifdef JUNCTION_NIGHT_FLASH_EN
                S_FLASH: begin
                    if (!night_mode) begin
                        r_state <= S_ALL_RED;
                        r_timer <= CNT_W'(ALLRED_CYC);
                        r_red   <= '1;
                        r_amber <= '0;
                    end else if (r_flash_cnt == CNT_W'(1)) begin
                        r_flash_on  <= ~r_flash_on;
                        r_flash_cnt <= CNT_W'(FLASH_CYC);
                        r_amber     <= r_flash_on ? '0 : '1;
                    end else begin
                        r_flash_cnt <= r_flash_cnt - CNT_W'(1);
                    end
                end
`endif
                default: begin
                    r_state <= S_ALL_RED;
                    r_timer <= CNT_W'(ALLRED_CYC);
                    r_red   <= '1;
                    r_amber <= '0;
                    r_green <= '0;
                end
            endcase
        end
    end

    assign red   = r_red;
    assign amber = r_amber;
    assign green = r_green;
    assign phase = r_phase;

endmodule

// File: tb/tb_junction_nway_ctrl.sv
// Directed bench for junction_nway_ctrl at default parameters; flash scenario with JUNCTION_NIGHT_FLASH_EN.
module tb_junction_nway_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] veh_req;
    logic [2:0] red, amber, green;
    logic [1:0] phase;
`ifdef JUNCTION_NIGHT_FLASH_EN
    logic       night_mode;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    junction_nway_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .veh_req    (veh_req),
`ifdef JUNCTION_NIGHT_FLASH_EN
        .night_mode (night_mode),
`endif
        .red        (red),
        .amber      (amber),
        .green      (green),
        .phase      (phase)
    );

    // kind: 0 all-red, 1 green on p, 2 amber on p, 3 flash on, 4 flash off
    function automatic logic [8:0] lamps(input int kind, input int p);
        logic [2:0] oh;
        oh = 3'b001 << p;
        case (kind)
            0:       return {3'b111, 3'b000, 3'b000};
            1:       return {~oh, 3'b000, oh};
            2:       return {~oh, oh, 3'b000};
            3:       return {3'b000, 3'b111, 3'b000};
            default: return 9'b0;
        endcase
    endfunction

    // Leaves the bench at a falling edge with rst just released (cycle 0, all-red).
    task automatic do_reset(input logic [2:0] req);
        rst = 1'b1;
        veh_req = req;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [8:0] exp;
        int k, p, kind, ph;
        rst = 1'b1;
        veh_req = 3'b000;
        @(negedge clk);
        checks++;
        if ({red, amber, green} !== lamps(0, 0)) begin
            errors++;
            $display("FAIL reset_lamps got %b want %b", {red, amber, green}, lamps(0, 0));
        end
        checks++;
        if (phase !== 2'd2) begin
            errors++;
            $display("FAIL reset_phase got %0d want 2", phase);
        end
        rst = 1'b0;
        for (int c = 0; c <= 22; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 0) begin
                kind = 0; ph = 2;
            end else begin
                k  = (c - 1) % 7;
                p  = ((c - 1) / 7) % 3;
                kind = (k < 4) ? 1 : (k < 6) ? 2 : 0;
                ph = p;
            end
            exp = lamps(kind, ph);
            checks++;
            if ({red, amber, green} !== exp) begin
                errors++;
                $display("FAIL fixed_time_lamps c=%0d got %b want %b", c, {red, amber, green}, exp);
            end
            checks++;
            if (phase !== 2'(ph)) begin
                errors++;
                $display("FAIL fixed_time_phase c=%0d got %0d want %0d", c, phase, ph);
            end
        end
    endtask

    task automatic test_demand_hold();
        int kinds [14];
        logic [8:0] exp;
        kinds = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 2, 2, 0, 1, 1};
        do_reset(3'b100);
        for (int c = 0; c < 14; c++) begin
            if (c > 0) @(negedge clk);
            exp = lamps(kinds[c], 2);
            checks++;
            if ({red, amber, green} !== exp) begin
                errors++;
                $display("FAIL hold_lamps c=%0d got %b want %b", c, {red, amber, green}, exp);
            end
            checks++;
            if (phase !== 2'd2) begin
                errors++;
                $display("FAIL hold_phase c=%0d got %0d want 2", c, phase);
            end
        end
    endtask

    task automatic test_extension_cut();
        int kinds [11];
        int phs [11];
        logic [8:0] exp;
        kinds = '{0, 1, 1, 1, 1, 1, 1, 2, 2, 0, 1};
        phs   = '{2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        do_reset(3'b001);
        for (int c = 0; c < 11; c++) begin
            if (c > 0) @(negedge clk);
            exp = lamps(kinds[c], phs[c]);
            checks++;
            if ({red, amber, green} !== exp) begin
                errors++;
                $display("FAIL extcut_lamps c=%0d got %b want %b", c, {red, amber, green}, exp);
            end
            checks++;
            if (phase !== 2'(phs[c])) begin
                errors++;
                $display("FAIL extcut_phase c=%0d got %0d want %0d", c, phase, phs[c]);
            end
            if (c == 6) veh_req = 3'b011;
        end
    endtask

    task automatic test_skip();
        int kinds [9];
        int phs [9];
        logic [8:0] exp;
        kinds = '{0, 1, 1, 1, 1, 2, 2, 0, 1};
        phs   = '{2, 0, 0, 0, 0, 0, 0, 0, 2};
        do_reset(3'b101);
        for (int c = 0; c < 9; c++) begin
            if (c > 0) @(negedge clk);
            exp = lamps(kinds[c], phs[c]);
            checks++;
            if ({red, amber, green} !== exp) begin
                errors++;
                $display("FAIL skip_lamps c=%0d got %b want %b", c, {red, amber, green}, exp);
            end
            checks++;
            if (phase !== 2'(phs[c])) begin
                errors++;
                $display("FAIL skip_phase c=%0d got %0d want %0d", c, phase, phs[c]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int kinds [7];
        int phs [7];
        logic [8:0] exp;
        kinds = '{0, 1, 1, 1, 1, 2, 2};
        phs   = '{2, 0, 0, 0, 0, 0, 0};
        do_reset(3'b000);
        for (int c = 0; c < 7; c++) begin
            if (c > 0) @(negedge clk);
            exp = lamps(kinds[c], phs[c]);
            checks++;
            if ({red, amber, green} !== exp) begin
                errors++;
                $display("FAIL midrst_pre c=%0d got %b want %b", c, {red, amber, green}, exp);
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({red, amber, green} !== lamps(0, 0) || phase !== 2'd2) begin
            errors++;
            $display("FAIL midrst_async got %b/%0d want %b/2", {red, amber, green}, phase, lamps(0, 0));
        end
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({red, amber, green} !== lamps(0, 0)) begin
            errors++;
            $display("FAIL midrst_allred got %b want %b", {red, amber, green}, lamps(0, 0));
        end
        @(negedge clk);
        checks++;
        if ({red, amber, green} !== lamps(1, 0) || phase !== 2'd0) begin
            errors++;
            $display("FAIL midrst_green got %b/%0d want %b/0", {red, amber, green}, phase, lamps(1, 0));
        end
    endtask

`ifdef JUNCTION_NIGHT_FLASH_EN
    task automatic test_flash();
        int kinds [9];
        int phs [9];
        logic [8:0] exp;
        kinds = '{0, 3, 3, 4, 4, 3, 3, 0, 1};
        phs   = '{2, 2, 2, 2, 2, 2, 2, 2, 0};
        night_mode = 1'b1;
        do_reset(3'b000);
        for (int c = 0; c < 9; c++) begin
            if (c > 0) @(negedge clk);
            exp = lamps(kinds[c], phs[c]);
            checks++;
            if ({red, amber, green} !== exp) begin
                errors++;
                $display("FAIL flash_lamps c=%0d got %b want %b", c, {red, amber, green}, exp);
            end
            checks++;
            if (phase !== 2'(phs[c])) begin
                errors++;
                $display("FAIL flash_phase c=%0d got %0d want %0d", c, phase, phs[c]);
            end
            if (c == 6) night_mode = 1'b0;
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        veh_req = 3'b000;
`ifdef JUNCTION_NIGHT_FLASH_EN
        night_mode = 1'b0;
`endif
        test_reset();
        test_demand_hold();
        test_extension_cut();
        test_skip();
        test_reset_mid();
`ifdef JUNCTION_NIGHT_FLASH_EN
        test_flash();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
